// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port, word-addressed data memory between two requesters.
//   port 0 : core load/store path (default priority holder)
//   port 1 : debug / program-loader path (protected from starvation)
//
// At most one access is granted per cycle. The granted port's request fields
// drive the memory directly. Load data from the memory is captured at the
// end of the grant cycle and returned one cycle later with an rvalid strobe.
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  - when defined, the wait counter is replaced by a
//                              priority flag that flips after every contended
//                              grant, so the two ports strictly alternate.
//                              When undefined, port 0 has fixed priority and
//                              port 1 takes priority after P_MAX_WAIT
//                              consecutive denied cycles.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_pN_req/we/addr/f3/wdata      request from port N (held until granted)
//   o_pN_gnt                       combinational grant, access happens now
//   o_pN_rvalid, o_pN_rdata        registered load response (1-cycle latency)
//   o_mem_we/addr/f3/wdata         memory command
//   i_mem_rdata                    memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int P_ADDR_WIDTH = 11,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_MAX_WAIT   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,

  input  logic                    i_p0_req,
  input  logic                    i_p0_we,
  input  logic [P_ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [2:0]              i_p0_f3,
  input  logic [P_DATA_WIDTH-1:0] i_p0_wdata,
  output logic                    o_p0_gnt,
  output logic                    o_p0_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_p0_rdata,

  input  logic                    i_p1_req,
  input  logic                    i_p1_we,
  input  logic [P_ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [2:0]              i_p1_f3,
  input  logic [P_DATA_WIDTH-1:0] i_p1_wdata,
  output logic                    o_p1_gnt,
  output logic                    o_p1_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_p1_rdata,

  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [2:0]              o_mem_f3,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

  // 1 when port 1 wins a contended cycle.
  logic prio1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic prio_reg;

  // Only contended grants move priority; an uncontested grant leaves it alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_reg <= 1'b0;
    end else if (i_p0_req && i_p1_req && (o_p0_gnt || o_p1_gnt)) begin
      prio_reg <= ~prio_reg;
    end
  end

  assign prio1 = prio_reg;
`else
  localparam logic [3:0] LP_MAX_WAIT = 4'(P_MAX_WAIT);

  logic [3:0] wait_cnt_reg;

  // Counts consecutive cycles port 1 asked and was refused. Any cycle port 1
  // is served or stops asking restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_reg <= 4'd0;
    end else if (!i_p1_req || o_p1_gnt) begin
      wait_cnt_reg <= 4'd0;
    end else if (wait_cnt_reg != LP_MAX_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end
  end

  assign prio1 = (wait_cnt_reg == LP_MAX_WAIT);
`endif

  // Grant: a lone requester always wins; under contention the priority holder
  // wins. Both grants are held low while reset is asserted.
  always_comb begin
    o_p0_gnt = 1'b0;
    o_p1_gnt = 1'b0;
    if (i_rst_n) begin
      if (i_p0_req && (!i_p1_req || !prio1)) begin
        o_p0_gnt = 1'b1;
      end else if (i_p1_req) begin
        o_p1_gnt = 1'b1;
      end
    end
  end

  // Memory command mux. With no grant the fields follow port 0 so the bus is
  // stable; the write enable is what keeps the memory safe.
  always_comb begin
    o_mem_we    = (o_p0_gnt & i_p0_we) | (o_p1_gnt & i_p1_we);
    o_mem_addr  = i_p0_addr;
    o_mem_f3    = i_p0_f3;
    o_mem_wdata = i_p0_wdata;
    if (o_p1_gnt) begin
      o_mem_addr  = i_p1_addr;
      o_mem_f3    = i_p1_f3;
      o_mem_wdata = i_p1_wdata;
    end
  end

  // Per-port load response registers.
  logic [1:0]              gnt;
  logic [1:0]              req_we;
  logic [1:0]              rvalid_reg;
  logic [P_DATA_WIDTH-1:0] rdata_reg [2];

  assign gnt    = {o_p1_gnt, o_p0_gnt};
  assign req_we = {i_p1_we, i_p0_we};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= '0;
        end else begin
          rvalid_reg[gi] <= gnt[gi] & ~req_we[gi];
          // Only a granted load updates the word; otherwise it is held.
          if (gnt[gi] && !req_we[gi]) begin
            rdata_reg[gi] <= i_mem_rdata;
          end
        end
      end
    end
  endgenerate

  assign o_p0_rvalid = rvalid_reg[0];
  assign o_p1_rvalid = rvalid_reg[1];
  assign o_p0_rdata  = rdata_reg[0];
  assign o_p1_rdata  = rdata_reg[1];

endmodule
